// File: rtl/cnu_serial_if.sv
// Handshake bundle for the serial check node unit:
// q input stream and r output stream with frame parity.
interface cnu_serial_if #(
    parameter int data_w = 8,
    parameter int in_w   = 11
);
    logic              in_valid;
    logic              in_ready;
    logic [in_w-1:0]   q_in;
    logic              out_valid;
    logic              out_ready;
    logic [data_w-1:0] r_out;
    logic              out_last;
    logic              parity_ok;

    modport master (
        output in_valid, q_in, out_ready,
        input  in_ready, out_valid, r_out, out_last, parity_ok
    );

    modport slave (
        input  in_valid, q_in, out_ready,
        output in_ready, out_valid, r_out, out_last, parity_ok
    );
endinterface

// File: rtl/cnu_serial.sv
// Serial min-sum check node unit: collect DC q messages, then emit DC r messages.
// Define CNU_OFFSET_EN for offset min-sum (BETA subtracted at emission).
module cnu_serial #(
    parameter int data_w = 8,
    parameter int in_w   = 11,
    parameter int DC     = 6,
    parameter int BETA   = 1
) (
    input logic         clk,
    input logic         rst_n,
    cnu_serial_if.slave bus
);
    localparam int MW   = data_w - 1;
    localparam int CW   = (DC > 2) ? $clog2(DC) : 1;
    localparam int MAXM = (1 << (data_w - 1)) - 1;
    localparam logic [CW-1:0] LAST = CW'(DC - 1);
    localparam logic [MW-1:0] MAXV = MW'(MAXM);
    localparam logic signed [in_w-1:0] MAXQ = in_w'(MAXM);
`ifdef CNU_OFFSET_EN
    localparam int OFF = BETA;
`else
    localparam int OFF = 0 * BETA;
`endif

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_EMIT} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_k;
    logic [CW-1:0]   r_e;
    logic [CW-1:0]   r_idx;
    logic [DC-1:0]   r_sgn;
    logic            r_tot;
    logic [MW-1:0]   r_min1;
    logic [MW-1:0]   r_min2;

    logic                   w_acc;
    logic                   w_xfer;
    logic signed [in_w-1:0] w_q;
    logic signed [in_w-1:0] w_clip;
    logic signed [in_w-1:0] w_abs;
    logic                   w_neg;
    logic [MW-1:0]          w_mag;
    logic                   w_t0;
    logic [MW-1:0]          w_m1;
    logic [MW-1:0]          w_m2;
    logic [MW-1:0]          w_m;
    logic [MW-1:0]          w_mo;
    logic [data_w-1:0]      w_sv;
    logic                   w_s;

    assign w_acc  = bus.in_valid && (r_state == S_COLLECT);
    assign w_xfer = bus.out_ready && (r_state == S_EMIT);
    assign w_q    = $signed(bus.q_in);

    // Saturate to the symmetric range so the magnitude fits MW bits
    always_comb begin
        w_clip = w_q;
        if (w_q > MAXQ)
            w_clip = MAXQ;
        else if (w_q < -MAXQ)
            w_clip = -MAXQ;
        w_abs = w_clip[in_w-1] ? -w_clip : w_clip;
        w_neg = w_clip[in_w-1];
        w_mag = w_abs[MW-1:0];
    end

    // First accept of a frame starts from fresh accumulators
    assign w_t0 = (r_k == '0) ? 1'b0 : r_tot;
    assign w_m1 = (r_k == '0) ? MAXV : r_min1;
    assign w_m2 = (r_k == '0) ? MAXV : r_min2;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:    w_next = S_COLLECT;
            S_COLLECT: if (w_acc && r_k == LAST) w_next = S_EMIT;
            S_EMIT:    if (w_xfer && r_e == LAST) w_next = S_COLLECT;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_k    <= '0;
            r_e    <= '0;
            r_idx  <= '0;
            r_sgn  <= '0;
            r_tot  <= 1'b0;
            r_min1 <= MAXV;
            r_min2 <= MAXV;
        end else begin
            if (w_acc) begin
                r_sgn[r_k] <= w_neg;
                r_tot      <= w_t0 ^ w_neg;
                r_k        <= (r_k == LAST) ? '0 : r_k + 1'b1;
                if (w_mag < w_m1) begin
                    r_min2 <= w_m1;
                    r_min1 <= w_mag;
                    r_idx  <= r_k;
                end else if (w_mag < w_m2) begin
                    r_min1 <= w_m1;
                    r_min2 <= w_mag;
                end else begin
                    r_min1 <= w_m1;
                    r_min2 <= w_m2;
                end
            end
            if (w_xfer)
                r_e <= (r_e == LAST) ? '0 : r_e + 1'b1;
        end
    end

    // Outputs derive from registers only, so they hold under backpressure
    always_comb begin
        bus.in_ready  = (r_state == S_COLLECT);
        bus.out_valid = 1'b0;
        bus.r_out     = '0;
        bus.out_last  = 1'b0;
        bus.parity_ok = 1'b0;
        w_m  = (r_e == r_idx) ? r_min2 : r_min1;
        w_mo = (w_m > MW'(OFF)) ? (w_m - MW'(OFF)) : '0;
        w_sv = {1'b0, w_mo};
        w_s  = r_tot ^ r_sgn[r_e];
        if (r_state == S_EMIT) begin
            bus.out_valid = 1'b1;
            bus.r_out     = w_s ? -w_sv : w_sv;
            bus.out_last  = (r_e == LAST);
            bus.parity_ok = ~r_tot;
        end
    end
endmodule

// File: tb/tb_cnu_serial.sv
// Scoreboard bench for cnu_serial: a min-sum model fills the queue,
// a negedge monitor pops and compares every r transfer.
module tb_cnu_serial;
    localparam int DW = 8;
    localparam int IW = 11;
    localparam int DC = 6;
    localparam int BETA = 1;
    localparam int MAXM = 127;

    typedef struct {
        logic [DW-1:0] r;
        bit            last;
        bit            par;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    bit   bp_en = 1'b0;
    int   nchk = 0;
    int   nfail = 0;
    exp_t sb[$];

    cnu_serial_if #(.data_w(DW), .in_w(IW)) bus ();

    cnu_serial #(.data_w(DW), .in_w(IW), .DC(DC), .BETA(BETA)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Each r is the sign product and minimum magnitude over the other inputs
    task automatic model_push(input int q[DC]);
        int mag[DC];
        bit sgn[DC];
        bit tot;
        int m;
        int rv;
        bit s;
        logic [DW-1:0] rb;
        exp_t x;
        tot = 0;
        for (int k = 0; k < DC; k++) begin
            int c;
            c = q[k];
            if (c > MAXM) c = MAXM;
            if (c < -MAXM) c = -MAXM;
            sgn[k] = (c < 0);
            mag[k] = (c < 0) ? -c : c;
            tot ^= sgn[k];
        end
        for (int e = 0; e < DC; e++) begin
            m = MAXM;
            s = 0;
            for (int j = 0; j < DC; j++)
                if (j != e) begin
                    if (mag[j] < m) m = mag[j];
                    s ^= sgn[j];
                end
`ifdef CNU_OFFSET_EN
            m = (m > BETA) ? m - BETA : 0;
`endif
            rv = s ? -m : m;
            rb = rv[DW-1:0];
            x.r = rb;
            x.last = (e == DC - 1);
            x.par = !tot;
            sb.push_back(x);
        end
    endtask

    task automatic send(input int q, input bit lastq);
        bit ok;
        int n;
        logic [IW-1:0] qb;
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
        end
        qb = q[IW-1:0];
        bus.q_in = qb;
        bus.in_valid = 1'b1;
        ok = 0;
        n = 0;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        bus.in_valid = 1'b0;
        if (!ok) begin
            nchk++;
            nfail++;
            $display("FAIL accept_timeout: got no in_ready expected accept");
        end else if (lastq) begin
            chk("latency_out_valid", int'(bus.out_valid), 1);
            chk("no_in_ready_emit", int'(bus.in_ready), 0);
        end
    endtask

    task automatic send_frame(input int q[DC]);
        model_push(q);
        for (int k = 0; k < DC; k++)
            send(q[k], k == DC - 1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_queue_empty", sb.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", int'(bus.in_ready), 0);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_r_out", int'(bus.r_out), 0);
        chk("rst_out_last", int'(bus.out_last), 0);
        chk("rst_parity_ok", int'(bus.parity_ok), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", int'(bus.in_ready), 0);
        @(posedge clk);
        #1;
        chk("collect_in_ready", int'(bus.in_ready), 1);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = bp_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    // Monitor: transfers are compared against the queue, stalls must hold
    initial begin
        bit stalled;
        exp_t hold;
        exp_t x;
        stalled = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 0;
            end else begin
                if (stalled) begin
                    chk("hold_valid", int'(bus.out_valid), 1);
                    chk("hold_r_out", int'(bus.r_out), int'(hold.r));
                    chk("hold_last", int'(bus.out_last), int'(hold.last));
                end
                stalled = 0;
                if (bus.out_valid && bus.out_ready) begin
                    if (sb.size() == 0) begin
                        nchk++;
                        nfail++;
                        $display("FAIL unexpected_output: got r=%0d expected none",
                                 bus.r_out);
                    end else begin
                        x = sb.pop_front();
                        chk("r_out", int'(bus.r_out), int'(x.r));
                        chk("out_last", int'(bus.out_last), int'(x.last));
                        chk("parity_ok", int'(bus.parity_ok), int'(x.par));
                    end
                end else if (bus.out_valid) begin
                    stalled = 1;
                    hold.r = bus.r_out;
                    hold.last = bus.out_last;
                end
            end
        end
    end

    initial begin
        int v1[DC] = '{5, -3, 7, -10, 2, 9};
        int v2[DC] = '{500, -600, 200, 300, 400, -1024};
        int v3[DC] = '{4, 4, -8, 8, 8, 8};
        int v0[DC] = '{0, 0, 0, 0, 0, 0};
        int vr[DC];
        bus.in_valid = 1'b0;
        bus.q_in = '0;
        bus.out_ready = 1'b1;
        do_reset();
        send_frame(v1);
        send_frame(v2);
        send_frame(v3);
        send_frame(v0);
        wait_drain();
        bp_en = 1'b1;
        send_frame(v1);
        wait_drain();
        bp_en = 1'b0;
        for (int k = 0; k < 3; k++)
            send(v3[k], 1'b0);
        do_reset();
        send_frame(v1);
        wait_drain();
        bp_en = 1'b1;
        for (int f = 0; f < 40; f++) begin
            for (int k = 0; k < DC; k++)
                if ($urandom_range(0, 1) == 1)
                    vr[k] = int'($urandom_range(0, 2047)) - 1024;
                else
                    vr[k] = int'($urandom_range(0, 24)) - 12;
            send_frame(vr);
        end
        wait_drain();
        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end
endmodule
